// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
//   DefaultWidth  : default operand/sum width in bits
//   DefaultStages : default pipeline depth
//   chunk_width() : bits added per stage (width / stages)
package pipe_adder_pkg;

    localparam int unsigned DefaultWidth  = 16;
    localparam int unsigned DefaultStages = 4;

    // A zero stage count yields zero so the caller's own parameter check can
    // report the problem instead of tripping a divide-by-zero at elaboration.
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

endpackage

// File: rtl/rca_stage.sv
// One combinational ripple-carry slice of the pipelined adder.
// Ports:
//   a_i, b_i   : Chunk-bit operand slices (b_i already inverted for subtract)
//   cin_i      : carry into bit 0 of the slice
//   sum_o      : Chunk-bit sum slice
//   cout_o     : carry out of the slice MSB
//   msb_cin_o  : carry into the slice MSB (used for signed overflow)
module rca_stage #(
    parameter int unsigned Chunk = 4
) (
    input  logic [Chunk-1:0] a_i,
    input  logic [Chunk-1:0] b_i,
    input  logic             cin_i,
    output logic [Chunk-1:0] sum_o,
    output logic             cout_o,
    output logic             msb_cin_o
);

    logic carry;

    always_comb begin
        carry     = cin_i;
        sum_o     = '0;
        msb_cin_o = 1'b0;
        for (int i = 0; i < int'(Chunk); i++) begin
            sum_o[i]  = a_i[i] ^ b_i[i] ^ carry;
            // Overwritten every bit; the last iteration leaves the MSB carry-in.
            msb_cin_o = carry;
            carry     = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/pipe_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshakes.
// Stage k adds chunk k of the operands; the not-yet-consumed operand bits
// travel forward (shifted down so the next chunk always sits at bit 0) and
// the partial sum accumulates in place.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake (a, b, cin, sub)
//   a, b                 : WIDTH-bit operands
//   cin                  : carry-in, ignored when sub=1
//   sub                  : 0 = a+b+cin, 1 = a-b
//   out_valid / out_ready: output handshake (sum, cout, ovf)
//   sum                  : WIDTH-bit result
//   cout                 : carry out of the MSB (for subtract, 1 = no borrow)
//   ovf                  : two's-complement signed overflow
module pipe_ripple_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned STAGES = DefaultStages
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipe_ripple_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    // Pipeline registers; entry k is the state held after stage k.
    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0]            carry_q, carry_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
    logic                         ovf_q, ovf_d;

    // Per-stage inputs: the handshake ports for stage 0, the previous stage
    // registers otherwise.
    logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_s;
    logic [STAGES-1:0]            st_cin, load;
    logic [STAGES-1:0][CHUNK-1:0] st_sum;
    logic [STAGES-1:0]            st_cout, st_msb_cin;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Subtract as a + ~b + 1.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : cin;

    assign out_valid = valid_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

    // A single global enable: the whole pipe freezes while the output is
    // blocked, so every stage (valid bits included) holds together.
    assign in_ready = !(out_valid && !out_ready);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_a[k]  = a;
            assign src_b[k]  = b_eff;
            assign src_s[k]  = '0;
            assign st_cin[k] = c_eff;
            assign load[k]   = in_valid;
        end else begin : g_body
            assign src_a[k]  = a_q[k-1];
            assign src_b[k]  = b_q[k-1];
            assign src_s[k]  = s_q[k-1];
            assign st_cin[k] = carry_q[k-1];
            assign load[k]   = valid_q[k-1];
        end

        rca_stage #(
            .Chunk (CHUNK)
        ) u_rca (
            .a_i       (src_a[k][CHUNK-1:0]),
            .b_i       (src_b[k][CHUNK-1:0]),
            .cin_i     (st_cin[k]),
            .sum_o     (st_sum[k]),
            .cout_o    (st_cout[k]),
            .msb_cin_o (st_msb_cin[k])
        );
    end

    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        ovf_d   = ovf_q;
        if (in_ready) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                valid_d[k] = load[k];
                // Data registers only move for real data; bubbles keep old
                // contents, which are don't-care while valid is low.
                if (load[k]) begin
                    a_d[k]     = src_a[k] >> CHUNK;
                    b_d[k]     = src_b[k] >> CHUNK;
                    s_d[k]     = src_s[k] | (WIDTH'(st_sum[k]) << (k * CHUNK));
                    carry_d[k] = st_cout[k];
                end
            end
            if (load[STAGES-1]) begin
                ovf_d = st_msb_cin[STAGES-1] ^ st_cout[STAGES-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operands are fully consumed by the last stage, and only the last stage's
    // MSB carry-in feeds ovf; these bits are intentionally left unread.
    logic unused_tail;
    assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], st_msb_cin};

endmodule

// File: doc/pipe_ripple_adder.md
PIPE_RIPPLE_ADDER -- requirements
Module: pipe_ripple_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; WIDTH % STAGES == 0 required; CHUNK = WIDTH/STAGES bits are added per stage.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; ignored when sub=1.
REQ-010 sub  input  1  0 = A+B+cin, 1 = A-B.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 cout  output  1  carry out of MSB; for sub, 1 means no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-017 Effective operation: A + (sub ? ~B : B) + (sub ? 1 : cin), computed modulo 2^WIDTH; cout = bit WIDTH of that sum.
REQ-018 Stage k (0..STAGES-1) adds chunk k of A and the B-operand with the carry from stage k-1 (stage 0 uses the effective carry-in) and registers the chunk result plus carry; higher chunks of A/B travel forward in registers, with delay alignment.
REQ-019 ovf = carry into MSB XOR carry out of MSB, registered with the final stage.
REQ-020 Latency: result of an accepted operand set appears with out_valid exactly STAGES cycles after acceptance, absent stalls.
REQ-021 Throughput: one operand set per cycle when out_ready held high; no bubbles inserted.
REQ-022 Stall: in_ready = !(out_valid && !out_ready); on stall every stage, including per-stage valid bits, holds its value.
REQ-023 While stalled, sum/cout/ovf/out_valid SHALL remain stable until transfer out.
REQ-024 Bubbles: stages without valid data propagate valid=0; out_valid=0 implies sum/cout/ovf content is don't-care.
REQ-025 Simultaneous in transfer and out transfer on the same cycle SHALL both complete; results emerge strictly in acceptance order.
REQ-026 Data accepted when in_valid=0 SHALL be none; input sampled only on in transfer.

Reset
REQ-027 On rst_n low, all stage valid bits clear immediately (asynchronous); out_valid=0, sum=0, cout=0, ovf=0.
REQ-028 in_ready SHALL read 1 during and after reset.
REQ-029 Reset mid-operation discards all in-flight results; none emerge after release.
REQ-030 First transfer possible on the first rising edge with rst_n high.

Structure
REQ-031 Package pipe_adder_pkg holds default WIDTH/STAGES constants and the CHUNK-width function.
REQ-032 Sub-module rca_stage: one CHUNK-wide combinational ripple slice (a, b, cin -> sum, cout, msb carry-in), instantiated STAGES times by a generate loop; registers live in the top module.
REQ-033 Elaboration SHALL fail when WIDTH % STAGES != 0 or STAGES < 1.

Verification (WIDTH=16, STAGES=4)
REQ-034 a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-035 a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1; a=0x0D, b=0x0E, cin=1 -> sum=0x001C, cout=0.
REQ-036 sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
REQ-037 Stream 8 back-to-back sets, out_ready=1 -> 8 results on 8 consecutive cycles, in order, in_ready never drops.
REQ-038 Stream with out_ready low 3 cycles mid-stream -> in_ready low for exactly those cycles, outputs stable, no loss or duplication.
REQ-039 Assert rst_n low with 3 sets in flight -> out_valid=0 immediately; no stale result after release; next set correct.
